// File: rtl/wb_scratch_slave.sv
// Wishbone classic-cycle scratchpad RAM responder with byte lanes, wait states and error capture.
// Misses and misaligned addresses terminate with err; acked accesses are counted.
module wb_scratch_slave #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_in,
  input  logic [31:0] wb_dat_in,
  input  logic [3:0]  wb_sel_in,
  input  logic        wb_cyc_in,
  input  logic        wb_stb_in,
  input  logic        wb_we_in,
  output logic [31:0] wb_dat_out,
  output logic        wb_ack_out,
  output logic        wb_err_out,
  output logic [15:0] access_count,
  output logic [31:0] err_adr
);

  localparam int unsigned Depth    = 2 ** ADDR_BITS;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);
  localparam bit          NoWait   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q;
  logic [3:0]            wait_cnt_q;
  logic [31:0]           adr_q;
  logic [31:0]           dat_q;
  logic [3:0]            sel_q;
  logic                  we_q;
  logic [15:0]           count_q;
  logic [31:0]           mem [Depth];

  logic [31:0]           cur_adr;
  logic [31:0]           cur_dat;
  logic [3:0]            cur_sel;
  logic                  cur_we;
  logic [ADDR_BITS-1:0]  cur_idx;
  logic                  hit;
  logic                  ok;
  logic                  respond;
  logic                  do_write;

  // With no wait states the response is decided straight from the bus in IDLE.
  always_comb begin
    if (state_q == StIdle) begin
      cur_adr = wb_adr_in;
      cur_dat = wb_dat_in;
      cur_sel = wb_sel_in;
      cur_we  = wb_we_in;
    end else begin
      cur_adr = adr_q;
      cur_dat = dat_q;
      cur_sel = sel_q;
      cur_we  = we_q;
    end
    hit     = (cur_adr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    ok      = hit && (cur_adr[1:0] == 2'b00);
    cur_idx = cur_adr[ADDR_BITS+1:2];
    unique case (state_q)
      StIdle:  respond = NoWait && wb_cyc_in && wb_stb_in;
      StWait:  respond = wb_cyc_in && (wait_cnt_q == 4'd1);
      default: respond = 1'b0;
    endcase
    do_write = respond && ok && cur_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      sel_q      <= 4'd0;
      we_q       <= 1'b0;
      count_q    <= 16'd0;
      wb_ack_out <= 1'b0;
      wb_err_out <= 1'b0;
      wb_dat_out <= 32'd0;
      err_adr    <= 32'd0;
    end else begin
      wb_ack_out <= 1'b0;
      wb_err_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wb_cyc_in && wb_stb_in) begin
            adr_q      <= wb_adr_in;
            dat_q      <= wb_dat_in;
            sel_q      <= wb_sel_in;
            we_q       <= wb_we_in;
            wait_cnt_q <= WaitLoad;
            state_q    <= NoWait ? StResp : StWait;
          end
        end
        StWait: begin
          if (!wb_cyc_in) begin
            state_q <= StIdle;
          end else if (respond) begin
            state_q <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (respond) begin
        if (ok) begin
          wb_ack_out <= 1'b1;
          count_q    <= count_q + 16'd1;
          if (!cur_we) wb_dat_out <= mem[cur_idx];
        end else begin
          wb_err_out <= 1'b1;
          err_adr    <= cur_adr;
          if (!cur_we) wb_dat_out <= 32'd0;
        end
      end
    end
  end

  // RAM has no reset; its contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  assign access_count = count_q;

endmodule

// File: tb/tb_wb_scratch_slave.sv
// Bench for wb_scratch_slave: three instances (1, 3 and 0 wait states) checked every cycle
// against a transaction-level model, plus literal expectations pinning the model.
module tb_wb_scratch_slave;

  localparam int unsigned WS [3] = '{1, 3, 0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] adr = 32'd0;
  logic [31:0] wdat = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic        we = 1'b0;
  logic [2:0]  cyc = 3'd0;
  logic [2:0]  stb = 3'd0;
  logic [31:0] rdat [3];
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [15:0] cnt [3];
  logic [31:0] eadr [3];

  // Model state
  logic [2:0]  exp_ack = 3'd0;
  logic [2:0]  exp_err = 3'd0;
  logic [31:0] exp_dat [3] = '{default: 32'd0};
  logic [15:0] exp_cnt [3] = '{default: 16'd0};
  logic [31:0] exp_eadr [3] = '{default: 32'd0};
  logic [31:0] mref [3][256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_scratch_slave #(.ADDR_BITS(8), .BASE_ADDR(32'h1000), .WAIT_STATES(1)) u0 (
    .clk(clk), .reset(reset), .wb_adr_in(adr), .wb_dat_in(wdat), .wb_sel_in(sel),
    .wb_cyc_in(cyc[0]), .wb_stb_in(stb[0]), .wb_we_in(we), .wb_dat_out(rdat[0]),
    .wb_ack_out(ack[0]), .wb_err_out(err[0]), .access_count(cnt[0]), .err_adr(eadr[0])
  );
  wb_scratch_slave #(.ADDR_BITS(8), .BASE_ADDR(32'h1000), .WAIT_STATES(3)) u1 (
    .clk(clk), .reset(reset), .wb_adr_in(adr), .wb_dat_in(wdat), .wb_sel_in(sel),
    .wb_cyc_in(cyc[1]), .wb_stb_in(stb[1]), .wb_we_in(we), .wb_dat_out(rdat[1]),
    .wb_ack_out(ack[1]), .wb_err_out(err[1]), .access_count(cnt[1]), .err_adr(eadr[1])
  );
  wb_scratch_slave #(.ADDR_BITS(8), .BASE_ADDR(32'h1000), .WAIT_STATES(0)) u2 (
    .clk(clk), .reset(reset), .wb_adr_in(adr), .wb_dat_in(wdat), .wb_sel_in(sel),
    .wb_cyc_in(cyc[2]), .wb_stb_in(stb[2]), .wb_we_in(we), .wb_dat_out(rdat[2]),
    .wb_ack_out(ack[2]), .wb_err_out(err[2]), .access_count(cnt[2]), .err_adr(eadr[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_ack", i), 32'(ack[i]), 32'(exp_ack[i]));
      chk($sformatf("u%0d_err", i), 32'(err[i]), 32'(exp_err[i]));
      chk($sformatf("u%0d_dat", i), rdat[i], exp_dat[i]);
      chk($sformatf("u%0d_cnt", i), 32'(cnt[i]), 32'(exp_cnt[i]));
      chk($sformatf("u%0d_eadr", i), eadr[i], exp_eadr[i]);
    end
  end

  // One classic access; the response is expected WS+1 edges after the request is driven.
  task automatic access(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit keep);
    int word;
    adr = a; wdat = d; sel = s; we = w; cyc[i] = 1'b1; stb[i] = 1'b1;
    repeat (WS[i] + 1) @(posedge clk);
    #1;
    if (a >= 32'h1000 && a < 32'h1400 && (a % 4) == 0) begin
      word = int'((a - 32'h1000) / 4);
      exp_ack[i] = 1'b1;
      exp_cnt[i] = exp_cnt[i] + 16'd1;
      if (w) begin
        for (int b = 0; b < 4; b++) if (s[b]) mref[i][word][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_dat[i] = mref[i][word];
      end
    end else begin
      exp_err[i] = 1'b1;
      exp_eadr[i] = a;
      if (!w) exp_dat[i] = 32'd0;
    end
    @(posedge clk);
    #1;
    exp_ack[i] = 1'b0;
    exp_err[i] = 1'b0;
    if (!keep) begin
      cyc[i] = 1'b0; stb[i] = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_ack", 32'(ack[0]), 32'd0);
    chk("reset_cnt", 32'(cnt[0]), 32'd0);

    // Full-word write then read, one wait state
    access(0, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 1'b0);
    access(0, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b0);
    chk("t1_rdata", rdat[0], 32'hDEADBEEF);
    chk("t1_count", 32'(cnt[0]), 32'd2);

    // Byte-lane merge
    access(0, 1'b1, 32'h1008, 32'h11223344, 4'hF, 1'b0);
    access(0, 1'b1, 32'h1008, 32'hAABBCCDD, 4'b0101, 1'b0);
    access(0, 1'b0, 32'h1008, 32'h0, 4'h0, 1'b0);
    chk("t2_rdata", rdat[0], 32'h11BB33DD);

    // Errors: out-of-window read, misaligned write
    access(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b0);
    access(0, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0);
    chk("t3_err_rdata", rdat[0], 32'h0);
    access(0, 1'b1, 32'h1002, 32'hFFFFFFFF, 4'hF, 1'b0);
    chk("t3_err_adr", eadr[0], 32'h1002);
    chk("t3_count", 32'(cnt[0]), 32'd6);
    access(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
    chk("t3_ram_kept", rdat[0], 32'hCAFEF00D);

    // Abort a write in cycle 2 with three wait states
    access(1, 1'b1, 32'h1010, 32'h12345678, 4'hF, 1'b0);
    adr = 32'h1010; wdat = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    access(1, 1'b0, 32'h1010, 32'h0, 4'hF, 1'b0);
    chk("t4_prior", rdat[1], 32'h12345678);
    chk("t4_count", 32'(cnt[1]), 32'd2);

    // Zero wait states with strobe held across four reads
    access(2, 1'b1, 32'h1000, 32'h0000AAAA, 4'hF, 1'b0);
    access(2, 1'b1, 32'h1004, 32'h55550000, 4'hF, 1'b0);
    access(2, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1);
    access(2, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b1);
    access(2, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1);
    access(2, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b0);
    chk("t5_rdata", rdat[2], 32'h55550000);
    chk("t5_count", 32'(cnt[2]), 32'd6);

    // Counter wrap: preset to FFFF, one more ack
    @(posedge clk);
    #1 force u2.count_q = 16'hFFFF;
    exp_cnt[2] = 16'hFFFF;
    #1 release u2.count_q;
    @(posedge clk);
    #1;
    chk("t6_preset", 32'(cnt[2]), 32'h0000FFFF);
    access(2, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b0);
    chk("t6_wrap", 32'(cnt[2]), 32'h0);

    // Reset mid-WAIT takes effect without a clock edge
    adr = 32'h1010; we = 1'b0; sel = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_ack[i] = 1'b0; exp_err[i] = 1'b0; exp_dat[i] = 32'd0;
      exp_cnt[i] = 16'd0; exp_eadr[i] = 32'd0;
    end
    #1;
    chk("t6_rst_ack", 32'(ack[1]), 32'd0);
    chk("t6_rst_dat", rdat[1], 32'd0);
    chk("t6_rst_cnt", 32'(cnt[1]), 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
